// File: rtl/ntt_pkg.sv
// ============================================================================
// Module      : ntt_pkg
// Description : Shared constants, state encoding and helpers for the NTT job
//               sequencer and its BRAM port mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ntt_pkg;

  localparam int Q      = 7681;
  localparam int N      = 8;
  localparam int N_INV  = 6721;  // 8 * 6721 == 1 (mod 7681)
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    ERST    = 4'd2,
    KICK    = 4'd3,
    RUN     = 4'd4,
    DRAIN   = 4'd5,
    UL_ADDR = 4'd6,
    UL_WAIT = 4'd7,
    UL_CAP  = 4'd8,
    UL_OUT  = 4'd9
  } ntt_job_state_t;

  function automatic logic out_of_range(input logic [DATA_W-1:0] d, input int q);
    return d >= DATA_W'(q);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_bram_mux.sv
// ============================================================================
// Module      : ntt_bram_mux
// Description : Combinational 2:1 select of the coefficient BRAM port between
//               the job controller and the NTT engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_bram_mux
  import ntt_pkg::*;
(
  input  logic              sel_eng,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic              ctrl_we,
  input  logic [DATA_W-1:0] ctrl_din,
  input  logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_we,
  input  logic [DATA_W-1:0] eng_din,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_din
);

  assign bram_addr = sel_eng ? eng_addr : ctrl_addr;
  assign bram_we   = sel_eng ? eng_we   : ctrl_we;
  assign bram_din  = sel_eng ? eng_din  : ctrl_din;

endmodule

`default_nettype wire

// File: rtl/ntt_job_ctrl.sv
// ============================================================================
// Module      : ntt_job_ctrl
// Description : Per-job sequencer: stream-load N coefficients into BRAM, reset
//               and start the NTT engine, hand it the BRAM, then stream out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_job_ctrl
  import ntt_pkg::*;
#(
  parameter int N       = ntt_pkg::N,
  parameter int Q       = ntt_pkg::Q,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              job_start,
  output logic              busy,
  output logic              job_done,
  output logic              err_range,
  output logic              err_timeout,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              eng_rst,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic [ADDR_W-1:0] eng_coeff_addr,
  input  logic              eng_coeff_we,
  input  logic [DATA_W-1:0] eng_coeff_din,
  output logic [DATA_W-1:0] eng_coeff_dout,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_we,
  output logic [DATA_W-1:0] bram_din,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  ntt_job_state_t    state_q, state_d;
  logic [7:0]        k_q, k_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              busy_q, busy_d;
  logic              job_done_q, job_done_d;
  logic              err_range_q, err_range_d;
  logic              err_timeout_q, err_timeout_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              eng_rst_q, eng_rst_d;
  logic              eng_start_q, eng_start_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic              bram_we_q, bram_we_d;
  logic [DATA_W-1:0] bram_din_q, bram_din_d;

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    wd_d          = wd_q;
    job_done_d    = 1'b0;
    err_range_d   = err_range_q;
    err_timeout_d = err_timeout_q;
    in_ready_d    = 1'b0;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    eng_rst_d     = 1'b0;
    eng_start_d   = 1'b0;
    bram_addr_d   = bram_addr_q;
    bram_we_d     = 1'b0;
    bram_din_d    = bram_din_q;

    case (state_q)
      IDLE: begin
        if (job_start) begin
          state_d       = LOAD;
          err_range_d   = 1'b0;
          err_timeout_d = 1'b0;
          k_d           = 8'd0;
          in_ready_d    = 1'b1;
        end
      end
      LOAD: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          bram_addr_d = ADDR_W'(k_q);
          bram_we_d   = 1'b1;
          if (out_of_range(in_data, Q)) begin
            bram_din_d  = '0;
            err_range_d = 1'b1;
          end else begin
            bram_din_d  = in_data;
          end
          // The last write is still in flight during ERST; the port stays ours.
          if (k_q == 8'(N - 1)) begin
            state_d    = ERST;
            in_ready_d = 1'b0;
            eng_rst_d  = 1'b1;
          end else begin
            k_d = k_q + 8'd1;
          end
        end
      end
      ERST: begin
        state_d     = KICK;
        eng_start_d = 1'b1;
      end
      KICK: begin
        state_d = RUN;
        wd_d    = '0;
      end
      RUN: begin
        if (eng_done) begin
          state_d = DRAIN;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d       = IDLE;
          err_timeout_d = 1'b1;
          eng_rst_d     = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = UL_ADDR;
        k_d     = 8'd0;
      end
      UL_ADDR: begin
        state_d     = UL_WAIT;
        bram_addr_d = ADDR_W'(k_q);
      end
      UL_WAIT: state_d = UL_CAP;
      UL_CAP: begin
        state_d     = UL_OUT;
        out_data_d  = bram_dout;
        out_valid_d = 1'b1;
      end
      UL_OUT: begin
        if (out_ready && out_valid_q) begin
          out_valid_d = 1'b0;
          if (k_q == 8'(N - 1)) begin
            state_d    = IDLE;
            job_done_d = 1'b1;
          end else begin
            state_d = UL_ADDR;
            k_d     = k_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      k_q           <= 8'd0;
      wd_q          <= '0;
      busy_q        <= 1'b0;
      job_done_q    <= 1'b0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      eng_rst_q     <= 1'b1;
      eng_start_q   <= 1'b0;
      bram_addr_q   <= '0;
      bram_we_q     <= 1'b0;
      bram_din_q    <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      wd_q          <= wd_d;
      busy_q        <= busy_d;
      job_done_q    <= job_done_d;
      err_range_q   <= err_range_d;
      err_timeout_q <= err_timeout_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      eng_rst_q     <= eng_rst_d;
      eng_start_q   <= eng_start_d;
      bram_addr_q   <= bram_addr_d;
      bram_we_q     <= bram_we_d;
      bram_din_q    <= bram_din_d;
    end
  end

  ntt_bram_mux u_bram_mux (
    .sel_eng   ((state_q == RUN) || (state_q == DRAIN)),
    .ctrl_addr (bram_addr_q),
    .ctrl_we   (bram_we_q),
    .ctrl_din  (bram_din_q),
    .eng_addr  (eng_coeff_addr),
    .eng_we    (eng_coeff_we),
    .eng_din   (eng_coeff_din),
    .bram_addr (bram_addr),
    .bram_we   (bram_we),
    .bram_din  (bram_din)
  );

  assign busy           = busy_q;
  assign job_done       = job_done_q;
  assign err_range      = err_range_q;
  assign err_timeout    = err_timeout_q;
  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign eng_rst        = eng_rst_q;
  assign eng_start      = eng_start_q;
  assign eng_coeff_dout = bram_dout;

endmodule

`default_nettype wire

// File: tb/tb_ntt_job_ctrl.sv
// ============================================================================
// Module      : tb_ntt_job_ctrl
// Description : Directed bench for ntt_job_ctrl with a BRAM model and an
//               engine stub that rewrites each word as (x + e_add) mod Q.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ntt_job_ctrl;

  localparam int NW = 8;
  localparam logic [31:0] QV = 32'd7681;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_start = 1'b0;
  logic        busy, job_done, err_range, err_timeout;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        eng_rst, eng_start;
  logic        eng_done;
  logic [7:0]  eng_coeff_addr;
  logic        eng_coeff_we;
  logic [31:0] eng_coeff_din, eng_coeff_dout;
  logic [7:0]  bram_addr;
  logic        bram_we;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;

  ntt_job_ctrl dut (
    .clk(clk), .rst_n(rst_n), .job_start(job_start), .busy(busy),
    .job_done(job_done), .err_range(err_range), .err_timeout(err_timeout),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .eng_rst(eng_rst), .eng_start(eng_start), .eng_done(eng_done),
    .eng_coeff_addr(eng_coeff_addr), .eng_coeff_we(eng_coeff_we),
    .eng_coeff_din(eng_coeff_din), .eng_coeff_dout(eng_coeff_dout),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din),
    .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  // BRAM model: one-cycle synchronous read.
  logic [31:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  // Engine stub: read word, write back (x + e_add) mod Q, sticky done.
  logic [31:0] e_add = '0;
  logic        e_hang = 1'b0;
  logic        e_run, e_ph, e_done;
  logic [7:0]  e_i;
  always @(posedge clk) begin
    if (eng_rst) begin
      e_run <= 1'b0; e_ph <= 1'b0; e_i <= '0; e_done <= 1'b0;
    end else if (eng_start) begin
      e_run <= !e_hang; e_ph <= 1'b0; e_i <= '0;
    end else if (e_run) begin
      if (!e_ph) e_ph <= 1'b1;
      else begin
        e_ph <= 1'b0;
        if (e_i == 8'(NW - 1)) begin e_run <= 1'b0; e_done <= 1'b1; end
        else e_i <= e_i + 8'd1;
      end
    end
  end
  assign eng_done       = e_done;
  assign eng_coeff_addr = e_i;
  assign eng_coeff_we   = e_run & e_ph;
  assign eng_coeff_din  = (eng_coeff_dout + e_add) % QV;

  int jd_cnt = 0, hs_cnt = 0, ov_cnt = 0;
  always @(posedge clk) begin
    if (job_done === 1'b1) jd_cnt++;
    if (out_valid === 1'b1 && out_ready === 1'b1) hs_cnt++;
    if (out_valid === 1'b1) ov_cnt++;
  end

  int chk = 0, pass = 0;
  logic [31:0] din_w [NW];
  logic [31:0] got_w [NW];
  int  ul_to, ld_to, bp_bad;
  logic jd_seen;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_job();
    job_start = 1'b1; tick(); job_start = 1'b0;
  endtask

  task automatic load_words(input int cnt);
    ld_to = 0;
    for (int i = 0; i < cnt; i++) begin
      int n = 0;
      in_valid = 1'b1; in_data = din_w[i];
      while (!in_ready && n < 20) begin tick(); n++; end
      if (n >= 20) ld_to++;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic unload(input int bp);
    ul_to = 0; bp_bad = 0; jd_seen = 1'b0;
    for (int i = 0; i < NW; i++) begin
      int n = 0;
      while (!out_valid && n < 200) begin tick(); n++; end
      if (n >= 200) begin ul_to++; break; end
      got_w[i] = out_data;
      for (int b = 0; b < bp; b++) begin
        tick();
        if (out_valid !== 1'b1 || out_data !== got_w[i]) bp_bad++;
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      if (i == NW - 1) jd_seen = job_done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    chk++;
    if ({busy, job_done, err_range, err_timeout, in_ready, out_valid, eng_start, bram_we, eng_rst} !== 9'b000000001)
      $display("FAIL reset_ctrl got %b exp 000000001",
               {busy, job_done, err_range, err_timeout, in_ready, out_valid, eng_start, bram_we, eng_rst});
    else pass++;
    chk++;
    if ({out_data, bram_addr, bram_din} !== 72'd0)
      $display("FAIL reset_data got %h exp 0", {out_data, bram_addr, bram_din});
    else pass++;
    rst_n = 1'b1; tick();
    chk++;
    if ({eng_rst, busy} !== 2'b00) $display("FAIL reset_release got %b exp 00", {eng_rst, busy});
    else pass++;
  endtask

  task automatic test_round_trip();
    e_add = 0; jd_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < NW; i++) din_w[i] = 32'(i + 1);
    start_job(); load_words(NW); unload(0); tick(); tick();
    for (int i = 0; i < NW; i++) begin
      chk++;
      if (got_w[i] !== 32'(i + 1)) $display("FAIL rt_word%0d got %0d exp %0d", i, got_w[i], i + 1);
      else pass++;
    end
    chk++;
    if ({ul_to, ld_to} !== 64'd0) $display("FAIL rt_stall got ul=%0d ld=%0d exp 0", ul_to, ld_to);
    else pass++;
    chk++;
    if (jd_seen !== 1'b1 || jd_cnt != 1) $display("FAIL rt_job_done got seen=%b cnt=%0d exp 1/1", jd_seen, jd_cnt);
    else pass++;
    chk++;
    if ({err_range, err_timeout, busy} !== 3'b000) $display("FAIL rt_flags got %b exp 000", {err_range, err_timeout, busy});
    else pass++;
  endtask

  task automatic test_range();
    e_add = 2;
    for (int i = 0; i < NW; i++) din_w[i] = 32'((i + 1) * 10);
    din_w[3] = QV;
    start_job(); load_words(NW);
    chk++;
    if ({eng_rst, err_range} !== 2'b11 || mem[3] !== 32'd0)
      $display("FAIL range_load got rst=%b err=%b mem3=%0d exp 1 1 0", eng_rst, err_range, mem[3]);
    else pass++;
    unload(0);
    for (int i = 0; i < NW; i++) begin
      logic [31:0] e;
      e = (i == 3) ? 32'd2 : 32'((i + 1) * 10 + 2);
      chk++;
      if (got_w[i] !== e) $display("FAIL range_word%0d got %0d exp %0d", i, got_w[i], e);
      else pass++;
    end
    chk++;
    if ({jd_seen, err_range, err_timeout} !== 3'b110)
      $display("FAIL range_end got %b exp 110", {jd_seen, err_range, err_timeout});
    else pass++;
  endtask

  task automatic test_backpressure();
    e_add = 5; hs_cnt = 0;
    for (int i = 0; i < NW; i++) din_w[i] = 32'(100 + 11 * i);
    start_job(); load_words(NW); unload(5); tick();
    chk++;
    if (bp_bad != 0 || ul_to != 0) $display("FAIL bp_stable got bad=%0d to=%0d exp 0", bp_bad, ul_to);
    else pass++;
    chk++;
    if (hs_cnt != NW) $display("FAIL bp_handshakes got %0d exp %0d", hs_cnt, NW);
    else pass++;
    for (int i = 0; i < NW; i++) begin
      chk++;
      if (got_w[i] !== 32'(105 + 11 * i)) $display("FAIL bp_word%0d got %0d exp %0d", i, got_w[i], 105 + 11 * i);
      else pass++;
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    e_hang = 1'b1;
    for (int i = 0; i < NW; i++) din_w[i] = 32'(i + 1);
    start_job(); load_words(NW);
    while (!eng_start && n < 20) begin tick(); n++; end
    ov_cnt = 0; n = 0;
    while (!err_timeout && n < 5000) begin tick(); n++; end
    chk++;
    if (n != 4097) $display("FAIL to_cycles got %0d exp 4097", n);
    else pass++;
    chk++;
    if ({eng_rst, busy, out_valid} !== 3'b100) $display("FAIL to_state got %b exp 100", {eng_rst, busy, out_valid});
    else pass++;
    tick(); tick();
    chk++;
    if ({eng_rst, err_timeout, busy} !== 3'b010 || ov_cnt != 0)
      $display("FAIL to_after got %b ov=%0d exp 010 ov=0", {eng_rst, err_timeout, busy}, ov_cnt);
    else pass++;
    e_hang = 1'b0;
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < NW; i++) din_w[i] = 32'(40 + i);
    start_job(); load_words(4);
    rst_n = 1'b0; tick();
    chk++;
    if ({busy, job_done, err_range, err_timeout, in_ready, out_valid, eng_start, bram_we, eng_rst} !== 9'b000000001 ||
        {out_data, bram_addr, bram_din} !== 72'd0)
      $display("FAIL midload_reset got %b %h exp 000000001 0",
               {busy, job_done, err_range, err_timeout, in_ready, out_valid, eng_start, bram_we, eng_rst},
               {out_data, bram_addr, bram_din});
    else pass++;
    rst_n = 1'b1; tick();
    e_add = 0;
    for (int i = 0; i < NW; i++) din_w[i] = 32'(i + 1);
    start_job(); load_words(NW); unload(0);
    for (int i = 0; i < NW; i++) begin
      chk++;
      if (got_w[i] !== 32'(i + 1)) $display("FAIL midload_word%0d got %0d exp %0d", i, got_w[i], i + 1);
      else pass++;
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    in_valid = 1'b1; in_data = 32'd55; tick(); tick();
    chk++;
    if ({in_ready, bram_we, busy} !== 3'b000) $display("FAIL idle_in_valid got %b exp 000", {in_ready, bram_we, busy});
    else pass++;
    in_valid = 1'b0;
    e_add = 9; jd_cnt = 0;
    for (int i = 0; i < NW; i++) din_w[i] = 32'(200 + i);
    start_job(); load_words(NW);
    while (!eng_start && n < 20) begin tick(); n++; end
    tick(); tick();
    job_start = 1'b1; tick(); job_start = 1'b0;
    unload(0); tick(); tick(); tick();
    for (int i = 0; i < NW; i++) begin
      chk++;
      if (got_w[i] !== 32'(209 + i)) $display("FAIL b2b_a_word%0d got %0d exp %0d", i, got_w[i], 209 + i);
      else pass++;
    end
    chk++;
    if (busy !== 1'b0 || jd_cnt != 1) $display("FAIL b2b_start_ignored got busy=%b jd=%0d exp 0/1", busy, jd_cnt);
    else pass++;
    // Engine done is still high from job A; job B must wait for the new pass.
    e_add = 1;
    for (int i = 0; i < NW; i++) din_w[i] = 32'(300 + 3 * i);
    start_job(); load_words(NW); unload(0);
    for (int i = 0; i < NW; i++) begin
      chk++;
      if (got_w[i] !== 32'(301 + 3 * i)) $display("FAIL b2b_b_word%0d got %0d exp %0d", i, got_w[i], 301 + 3 * i);
      else pass++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got hang exp finish");
    $fatal(1, "global time limit");
  end

  initial begin
    test_reset();
    test_round_trip();
    test_range();
    test_backpressure();
    test_timeout();
    test_reset_midload();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

`default_nettype wire
